// File: rtl/registro_seq_ctrl_if.sv
// Bundle between the host, the sequencer and the shift register it drives.
// SHIFT_TOTAL exists only when RSC_SHIFT_STATS_EN is defined.
interface registro_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    // START is a strobe taken only while the sequencer is idle; BUSY covers
    // LOAD/SHIFT/CAPTURE and DONE is a single-cycle pulse after the capture.
    logic             START;
    logic [1:0]       OP;
    logic [CNT_W-1:0] COUNT;
    logic             DIR_IN;
    logic [WIDTH-1:0] DATA_IN;
    logic             SER_IN;
    logic [WIDTH-1:0] REG_Q;
    logic             REG_S_OUT;
    logic             REG_ENB;
    logic [1:0]       REG_MODO;
    logic             REG_DIR;
    logic [WIDTH-1:0] REG_D;
    logic             REG_S_IN;
    logic             BUSY;
    logic             DONE;
    logic             SER_OUT;
    logic             SER_OUT_VALID;
    logic [WIDTH-1:0] DATA_OUT;
`ifdef RSC_SHIFT_STATS_EN
    logic [15:0]      SHIFT_TOTAL;
`endif

    modport master (
        output START, OP, COUNT, DIR_IN, DATA_IN, SER_IN, REG_Q, REG_S_OUT,
        input  REG_ENB, REG_MODO, REG_DIR, REG_D, REG_S_IN,
        input  BUSY, DONE, SER_OUT, SER_OUT_VALID, DATA_OUT
`ifdef RSC_SHIFT_STATS_EN
        , input SHIFT_TOTAL
`endif
    );

    modport slave (
        input  START, OP, COUNT, DIR_IN, DATA_IN, SER_IN, REG_Q, REG_S_OUT,
        output REG_ENB, REG_MODO, REG_DIR, REG_D, REG_S_IN,
        output BUSY, DONE, SER_OUT, SER_OUT_VALID, DATA_OUT
`ifdef RSC_SHIFT_STATS_EN
        , output SHIFT_TOTAL
`endif
    );
endinterface

// File: rtl/registro_seq_ctrl.sv
// Sequencer issuing LOAD/PUSH/CYCLE cycles to one shift register per command.
// Optional RSC_SHIFT_STATS_EN adds a saturating count of shift/rotate cycles.
`ifndef LOAD
`define LOAD  2'b00
`endif
`ifndef PUSH
`define PUSH  2'b01
`endif
`ifndef CYCLE
`define CYCLE 2'b10
`endif

module registro_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    registro_seq_ctrl_if.slave   bus,
    output logic [2:0]           dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    localparam logic [1:0] OP_SHIFT_OUT = 2'b00;
    localparam logic [1:0] OP_ROTATE    = 2'b01;
    localparam logic [1:0] OP_SHIFT_IN  = 2'b10;

    state_t           state, state_nx;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_out_q;
    logic             ser_valid_q;

    logic             enb;
    logic [1:0]       modo;
    logic             reg_dir;
    logic [WIDTH-1:0] reg_d;
    logic             reg_s_in;
    logic             busy;
    logic             done;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            data_q      <= '0;
            data_out_q  <= '0;
            ser_valid_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && bus.START) begin
                op_q   <= bus.OP;
                cnt_q  <= bus.COUNT;
                dir_q  <= bus.DIR_IN;
                data_q <= bus.DATA_IN;
            end else if (state == S_SHIFT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (state == S_CAPTURE) begin
                data_out_q <= bus.REG_Q;
            end
            // The register's S_OUT settles on the PUSH edge, so qualify one cycle later.
            ser_valid_q <= (state == S_SHIFT) && (op_q == OP_SHIFT_OUT);
        end
    end

    always_comb begin
        state_nx = state;
        enb      = 1'b0;
        modo     = `LOAD;
        reg_dir  = 1'b0;
        reg_d    = '0;
        reg_s_in = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.START) begin
                    if (bus.OP == OP_SHIFT_IN) begin
                        state_nx = (bus.COUNT != '0) ? S_SHIFT : S_CAPTURE;
                    end else begin
                        state_nx = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                busy  = 1'b1;
                enb   = 1'b1;
                modo  = `LOAD;
                reg_d = data_q;
                if ((op_q == OP_SHIFT_OUT || op_q == OP_ROTATE) && cnt_q != '0) begin
                    state_nx = S_SHIFT;
                end else begin
                    state_nx = S_CAPTURE;
                end
            end
            S_SHIFT: begin
                busy     = 1'b1;
                enb      = 1'b1;
                reg_dir  = dir_q;
                modo     = (op_q == OP_ROTATE) ? `CYCLE : `PUSH;
                reg_s_in = (op_q == OP_SHIFT_IN) ? bus.SER_IN : 1'b0;
                if (cnt_q <= CNT_W'(1)) begin
                    state_nx = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                busy     = 1'b1;
                state_nx = S_FIN;
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign bus.REG_ENB       = enb;
    assign bus.REG_MODO      = modo;
    assign bus.REG_DIR       = reg_dir;
    assign bus.REG_D         = reg_d;
    assign bus.REG_S_IN      = reg_s_in;
    assign bus.BUSY          = busy;
    assign bus.DONE          = done;
    assign bus.SER_OUT_VALID = ser_valid_q;
    assign bus.SER_OUT       = ser_valid_q & bus.REG_S_OUT;
    assign bus.DATA_OUT      = data_out_q;
    assign dbg_state         = state;

`ifdef RSC_SHIFT_STATS_EN
    logic [15:0] shift_total_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            shift_total_q <= '0;
        end else if (enb && modo != `LOAD && shift_total_q != 16'hFFFF) begin
            shift_total_q <= shift_total_q + 16'd1;
        end
    end

    assign bus.SHIFT_TOTAL = shift_total_q;
`endif
endmodule

// File: tb/tb_registro_seq_ctrl.sv
// Directed bench for registro_seq_ctrl with a behavioural 4-bit shift register.
// Build with RSC_SHIFT_STATS_EN defined to also cover SHIFT_TOTAL.
`ifndef LOAD
`define LOAD  2'b00
`endif
`ifndef PUSH
`define PUSH  2'b01
`endif
`ifndef CYCLE
`define CYCLE 2'b10
`endif

module tb_registro_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [0:0] exp_q[$];

    int res_done_edge;
    int res_busy;
    int res_valid;
    int res_extra;

    logic [3:0] model_q     = 4'h0;
    logic       model_s_out = 1'b0;

    registro_seq_ctrl_if #(.WIDTH(4), .CNT_W(4)) bus ();

    registro_seq_ctrl #(.WIDTH(4), .CNT_W(4)) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // shift register partner: DIR=0 shifts toward the MSB, S_OUT holds the bit pushed out
    always @(posedge clk) begin
        if (bus.REG_ENB) begin
            case (bus.REG_MODO)
                `LOAD: model_q <= bus.REG_D;
                `PUSH: begin
                    if (!bus.REG_DIR) begin
                        model_s_out <= model_q[3];
                        model_q     <= {model_q[2:0], bus.REG_S_IN};
                    end else begin
                        model_s_out <= model_q[0];
                        model_q     <= {bus.REG_S_IN, model_q[3:1]};
                    end
                end
                `CYCLE: begin
                    if (!bus.REG_DIR) model_q <= {model_q[2:0], model_q[3]};
                    else              model_q <= {model_q[0], model_q[3:1]};
                end
                default: ;
            endcase
        end
    end

    assign bus.REG_Q     = model_q;
    assign bus.REG_S_OUT = model_s_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {13'd0, bus.REG_ENB, bus.REG_MODO, bus.REG_DIR, bus.REG_D, bus.REG_S_IN,
                bus.BUSY, bus.DONE, bus.SER_OUT, bus.SER_OUT_VALID, bus.DATA_OUT, dbg_state};
    endfunction

    task automatic sample();
        res_busy += int'(bus.BUSY);
        if (bus.SER_OUT_VALID) begin
            res_valid++;
            if (exp_q.size() == 0) check("ser_extra_bit", 32'd1, 32'd0);
            else                   check("ser_bit", {31'd0, bus.SER_OUT}, {31'd0, exp_q.pop_front()});
        end
    endtask

    // Launches a command on edge e0 (START sampled at e1) and records DONE edge,
    // BUSY cycles and serial bits. With stray=1, START is re-pulsed with other
    // operands during LOAD, CAPTURE and FIN.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] count, input logic dir,
                           input logic [3:0] data, input logic [15:0] ser_bits, input bit stray);
        int  e;
        bit  seen;
        e = 0; seen = 0;
        res_done_edge = -1; res_busy = 0; res_valid = 0; res_extra = 0;
        @(posedge clk); #1;
        bus.START = 1'b1; bus.OP = op; bus.COUNT = count;
        bus.DIR_IN = dir; bus.DATA_IN = data; bus.SER_IN = 1'b0;
        while (!seen && e < 40) begin
            @(posedge clk); #1;
            e++;
            if (e == 1) begin
                bus.START = stray;
                if (stray) begin
                    bus.OP = 2'b00; bus.COUNT = 4'd3; bus.DATA_IN = ~data;
                end
            end
            bus.SER_IN = (e <= 16) ? ser_bits[e-1] : 1'b0;
            sample();
            if (bus.DONE) begin
                seen = 1;
                res_done_edge = e;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            bus.START = 1'b0;
            res_extra += int'(bus.DONE) + int'(bus.BUSY);
            sample();
        end
        check("ser_missing_bits", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.START = 1'b0; bus.OP = 2'b00; bus.COUNT = 4'd0;
        bus.DIR_IN = 1'b0; bus.DATA_IN = 4'h0; bus.SER_IN = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", out_vec(), 32'd0);
`ifdef RSC_SHIFT_STATS_EN
        check("reset_shift_total", {16'd0, bus.SHIFT_TOTAL}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // LOAD_SHIFT_OUT 1011, left, 4 pushes
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        run_cmd(2'b00, 4'd4, 1'b0, 4'b1011, 16'h0000, 1'b0);
        check("so_data_out", {28'd0, bus.DATA_OUT}, 32'h0);
        check("so_done_edge", res_done_edge, 32'd7);
        check("so_valid_cnt", res_valid, 32'd4);
        check("so_busy_cycles", res_busy, 32'd6);
        check("so_done_single", res_extra, 32'd0);

        // LOAD_ROTATE 1000, right, 5 rotates (wraps past WIDTH)
        run_cmd(2'b01, 4'd5, 1'b1, 4'b1000, 16'h0000, 1'b0);
        check("rot_data_out", {28'd0, bus.DATA_OUT}, 32'h4);
        check("rot_valid_cnt", res_valid, 32'd0);
        check("rot_busy_cycles", res_busy, 32'd7);
        check("rot_done_edge", res_done_edge, 32'd8);
`ifdef RSC_SHIFT_STATS_EN
        check("shift_total", {16'd0, bus.SHIFT_TOTAL}, 32'd9);
`endif

        // LOAD_ONLY with START re-pulsed while busy and in FIN
        run_cmd(2'b11, 4'd7, 1'b0, 4'hA, 16'h0000, 1'b1);
        check("lo_data_out", {28'd0, bus.DATA_OUT}, 32'hA);
        check("lo_done_edge", res_done_edge, 32'd3);
        check("lo_busy_cycles", res_busy, 32'd2);
        check("lo_stray_ignored", res_extra, 32'd0);

        // preset register to 0, then SHIFT_IN 1,1,0,1
        run_cmd(2'b11, 4'd0, 1'b0, 4'h0, 16'h0000, 1'b0);
        check("preset_data_out", {28'd0, bus.DATA_OUT}, 32'h0);
        run_cmd(2'b10, 4'd4, 1'b0, 4'hF, 16'h000B, 1'b0);
        check("si_data_out", {28'd0, bus.DATA_OUT}, 32'hD);
        check("si_done_edge", res_done_edge, 32'd6);
        check("si_busy_cycles", res_busy, 32'd5);
        check("si_valid_cnt", res_valid, 32'd0);

        // reset in the middle of SHIFT of LOAD_SHIFT_OUT, COUNT=6
        @(posedge clk); #1;
        bus.START = 1'b1; bus.OP = 2'b00; bus.COUNT = 4'd6;
        bus.DIR_IN = 1'b0; bus.DATA_IN = 4'hF;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_abort_valid", {31'd0, bus.SER_OUT_VALID}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", out_vec(), 32'd0);
`ifdef RSC_SHIFT_STATS_EN
        check("abort_shift_total", {16'd0, bus.SHIFT_TOTAL}, 32'd0);
`endif
        res_extra = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            res_extra += int'(bus.DONE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            res_extra += int'(bus.DONE);
        end
        check("abort_no_done", res_extra, 32'd0);

        // recovery with COUNT=0 on a loading op
        run_cmd(2'b00, 4'd0, 1'b0, 4'h6, 16'h0000, 1'b0);
        check("rec_data_out", {28'd0, bus.DATA_OUT}, 32'h6);
        check("rec_done_edge", res_done_edge, 32'd3);
        check("rec_valid_cnt", res_valid, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
